// File: rtl/action_scheduler.sv
// Epsilon-greedy action scheduler: round-robin grants over N_REQ agents sharing
// one 16-bit LFSR that advances only when a draw is made.
module action_scheduler #(
  parameter int          N_REQ = 4,
  parameter logic [15:0] SEED  = 16'h97B2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_REQ-1:0]     Req,
  input  logic [2*N_REQ-1:0]   Greedy_Action,
  input  logic [7:0]           Epsilon,
  output logic [N_REQ-1:0]     Grant,
  output logic [1:0]           Action_Out,
  output logic                 Explore,
  output logic                 Valid,
  output logic [15:0]          Draw_Count,
  output logic [1:0]           State_Dbg
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Handshake: Req is a level held until Grant. Grant/Valid pulse for one
  // cycle together; Action_Out/Explore are valid in that cycle and hold after.
  typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, RESP = 2'd2} state_t;

  state_t          state, state_nx;
  logic [15:0]     s;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   idx;
  logic [PW-1:0]   win_idx;
  logic            found;
  logic [15:0]     lfsr_nx;
  logic            explore_d;
  logic [1:0]      greedy_sel;

  assign State_Dbg  = state;
  assign lfsr_nx    = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[11]};
  assign explore_d  = (s[7:0] < Epsilon);
  assign greedy_sel = Greedy_Action[{idx, 1'b0} +: 2];

  // First set request at or above ptr, wrapping modulo N_REQ.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int j = 0; j < N_REQ; j++) begin
      int c;
      c = (int'(ptr) + j) % N_REQ;
      if (!found && Req[c]) begin
        found   = 1'b1;
        win_idx = PW'(c);
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|Req) state_nx = DRAW;
      DRAW:    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      s          <= SEED;
      ptr        <= '0;
      idx        <= '0;
      Grant      <= '0;
      Valid      <= 1'b0;
      Explore    <= 1'b0;
      Action_Out <= 2'b00;
      Draw_Count <= 16'd0;
    end else begin
      state <= state_nx;
      Grant <= '0;
      Valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|Req) idx <= win_idx;
        end
        DRAW: begin
          Explore    <= explore_d;
          Action_Out <= explore_d ? s[15:14] : greedy_sel;
          s          <= lfsr_nx;
        end
        RESP: begin
          Valid      <= 1'b1;
          Grant      <= {{(N_REQ-1){1'b0}}, 1'b1} << idx;
          Draw_Count <= Draw_Count + 16'd1;
          ptr        <= (idx == PW'(N_REQ - 1)) ? '0 : idx + PW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_action_scheduler.sv
// Bench for action_scheduler: directed scenarios plus randomized draws checked
// against a transaction-level model of the arbiter and the shared LFSR.
module tb_action_scheduler;

  logic        CLK;
  logic        RST;
  logic [3:0]  Req;
  logic [7:0]  Greedy_Action;
  logic [7:0]  Epsilon;
  logic [3:0]  Grant;
  logic [1:0]  Action_Out;
  logic        Explore;
  logic        Valid;
  logic [15:0] Draw_Count;
  logic [1:0]  State_Dbg;

  int vectors;
  int miscompares;

  // Reference model state
  logic [15:0] m_s;
  int          m_ptr;
  logic [15:0] m_cnt;
  logic [1:0]  last_act;
  logic        last_exp;

  action_scheduler #(.N_REQ(4), .SEED(16'h97B2)) dut (
    .CLK(CLK), .RST(RST), .Req(Req), .Greedy_Action(Greedy_Action),
    .Epsilon(Epsilon), .Grant(Grant), .Action_Out(Action_Out),
    .Explore(Explore), .Valid(Valid), .Draw_Count(Draw_Count),
    .State_Dbg(State_Dbg)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[11]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s      = 16'h97B2;
    m_ptr    = 0;
    m_cnt    = 16'd0;
    last_act = 2'b00;
    last_exp = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge CLK);
    Req = '0;
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_valid",  32'(Valid),      32'd0);
    chk("rst_grant",  32'(Grant),      32'd0);
    chk("rst_action", 32'(Action_Out), 32'd0);
    chk("rst_explore",32'(Explore),    32'd0);
    chk("rst_count",  32'(Draw_Count), 32'd0);
    RST = 1'b1;
    model_reset();
    @(negedge CLK);
  endtask

  // Driver: apply one request pattern at a negedge while the DUT is idle,
  // wait for the response and compare it with the model's prediction.
  task automatic issue(input logic [3:0] req, input logic [7:0] ga,
                       input logic [7:0] eps, input bit drop);
    int         w;
    int         lat;
    bit         got;
    logic       ex;
    logic [1:0] act;
    w = -1;
    for (int j = 0; j < 4; j++) begin
      int c;
      c = (m_ptr + j) % 4;
      if (w < 0 && req[c]) w = c;
    end
    ex  = (m_s[7:0] < eps);
    act = ex ? m_s[15:14] : ga[2*w +: 2];
    Req = req; Greedy_Action = ga; Epsilon = eps;
    lat = 0; got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge CLK);
      lat++;
      if (lat == 1) begin
        chk("hold_action",  32'(Action_Out), 32'(last_act));
        chk("hold_explore", 32'(Explore),    32'(last_exp));
        if (drop) Req = '0;
      end
      if (Valid) got = 1'b1;
    end
    chk("latency", 32'(lat), 32'd3);
    m_s      = lfsr_step(m_s);
    m_cnt    = m_cnt + 16'd1;
    m_ptr    = (w + 1) % 4;
    last_act = act;
    last_exp = ex;
    if (got) begin
      chk("grant",   32'(Grant),      32'(4'b0001 << w));
      chk("action",  32'(Action_Out), 32'(act));
      chk("explore", 32'(Explore),    32'(ex));
      chk("count",   32'(Draw_Count), 32'(m_cnt));
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    RST = 1'b0; Req = '0; Greedy_Action = '0; Epsilon = '0;
    model_reset();

    // Seed draw explores, second draw hits the rnd == Epsilon boundary
    reset_dut();
    issue(4'b0001, 8'h01, 8'd200, 1'b0);
    chk("s1_action_lit",  32'(Action_Out), 32'd2);
    chk("s1_explore_lit", 32'(Explore),    32'd1);
    issue(4'b0001, 8'h01, 8'd100, 1'b0);
    chk("s2_action_lit",  32'(Action_Out), 32'd1);
    chk("s2_explore_lit", 32'(Explore),    32'd0);
    chk("s2_lfsr_model",  32'(m_s),        32'h5EC8);
    Req = '0;

    // All agents requesting: rotation 0,1,2,3,0
    reset_dut();
    for (int k = 0; k < 5; k++) issue(4'b1111, 8'hE4, 8'd128, 1'b0);
    chk("rr_count", 32'(Draw_Count), 32'd5);
    Req = '0;

    // Epsilon = 0 never explores, LFSR still advances per draw
    for (int k = 0; k < 64; k++)
      issue(4'($urandom_range(1, 15)), 8'hFF, 8'd0, 1'b0);
    Req = '0;

    // Agent 2 drops its request after selection; grant still issued, ptr -> 3
    issue(4'b0100, 8'h30, 8'd0, 1'b1);
    issue(4'b1111, 8'hC0, 8'd0, 1'b0);
    chk("after_drop_grant", 32'(Grant), 32'b1000);
    Req = '0;

    // Reset during DRAW aborts the draw and restores the seed
    reset_dut();
    Req = 4'b0001; Greedy_Action = 8'h01; Epsilon = 8'd200;
    @(negedge CLK);
    RST = 1'b0;
    Req = '0;
    repeat (2) begin
      @(negedge CLK);
      chk("abort_valid", 32'(Valid), 32'd0);
    end
    chk("abort_count", 32'(Draw_Count), 32'd0);
    RST = 1'b1;
    model_reset();
    @(negedge CLK);
    issue(4'b0001, 8'h01, 8'd200, 1'b0);
    chk("s5_action_lit", 32'(Action_Out), 32'd2);
    chk("s5_count_lit",  32'(Draw_Count), 32'd1);

    // Randomized draws, including epsilon extremes
    for (int k = 0; k < 60; k++) begin
      logic [7:0] eps;
      case ($urandom_range(0, 3))
        0:       eps = 8'd0;
        1:       eps = 8'd255;
        default: eps = 8'($urandom);
      endcase
      issue(4'($urandom_range(1, 15)), 8'($urandom), eps, 1'($urandom_range(0, 1)));
    end
    Req = '0;
    repeat (3) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/action_scheduler.md
# action_scheduler

Shares one 16-bit LFSR random source among several learning agents in the parallel implementation and performs the epsilon-greedy action choice for each of them. Agents raise a request together with their greedy action. The scheduler grants them round-robin and draws one random word per grant. It returns either the random action (explore) or the agent's greedy action (exploit). The LFSR advances only when a draw is made, so the random sequence seen by the agents is reproducible from the seed.

## Interface
- N_REQ, 4: number of requesting agents (2..8)
- SEED, 16'h97B2: LFSR value loaded at reset
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous reset, active-low
- Req  in  N_REQ  per-agent request level; held until that agent's Grant
- Greedy_Action  in  2*N_REQ  greedy action of agent i in bits [2i+1:2i]
- Epsilon  in  8  explore threshold; explore when rnd < Epsilon
- Grant  out  N_REQ  one-hot, single-cycle pulse to the served agent
- Action_Out  out  2  chosen action, valid while Valid=1
- Explore  out  1  1 = Action_Out is random, 0 = greedy
- Valid  out  1  single-cycle pulse, coincident with Grant
- Draw_Count  out  16  number of completed draws, wraps 16'hFFFF->0

## Operation
- LFSR s[15:0]: next = {s[14:0], s[15]^s[13]^s[12]^s[11]}. It shifts only in state DRAW.
- Random fields taken from s before the shift: rnd = s[7:0], rand_action = s[15:14].
- Round-robin pointer ptr (log2 N_REQ bits), reset 0. The search starts at ptr and wraps upward modulo N_REQ. The first set Req bit wins and is latched as idx.
- FSM:
  - IDLE: if |Req, latch idx, go to DRAW; otherwise stay.
  - DRAW: Explore_r = (rnd < Epsilon). Action_r = Explore_r ? rand_action : Greedy_Action[2idx+1:2idx]. Shift the LFSR and go to RESP.
  - RESP: Valid=1, Grant[idx]=1, Draw_Count += 1, ptr = (idx+1) mod N_REQ, go to IDLE.
- Greedy_Action and Epsilon are sampled only at the DRAW edge.
- Once idx is latched the grant is committed. Dropping Req in DRAW does not cancel the response.
- Epsilon = 0: never explore. Epsilon = 255: explore unless rnd = 255.
- Req bits set during DRAW or RESP are considered at the next IDLE.

## Timing
- Reset (RST low, asynchronous): state=IDLE, s=SEED, ptr=0, idx=0, Grant=0, Valid=0, Explore=0, Action_Out=0, Draw_Count=0.
- Reset mid-operation aborts the cycle: no Valid/Grant is issued, the LFSR returns to SEED, and the draw is not counted.
- Latency: Req sampled high at edge k (IDLE) → DRAW after edge k → Valid/Grant high during the cycle after edge k+2. One grant every 3 cycles maximum.
- Action_Out and Explore are registered. They hold their value after Valid drops until the next DRAW.
- Grant and Valid are never high for more than one consecutive cycle.
- Requesters must sample Action_Out in the Grant cycle. They may drop Req on the edge that ends Grant.

## Test plan
- After reset, Req=4'b0001, Greedy_Action[1:0]=2'b01, Epsilon=200. Expected: rnd=0xB2=178 < 200, so Grant=0001, Valid=1, Explore=1, Action_Out=2'b10 in the 3rd cycle after Req; LFSR becomes 16'h2F64; Draw_Count=1.
- Second draw on the same agent with Epsilon=100. Expected: rnd=0x64=100, not less than 100, so Explore=0 and Action_Out=2'b01 (greedy boundary); LFSR becomes 16'h5EC8.
- Req=4'b1111 held from reset. Expected: Grant order 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart; Draw_Count=5.
- Epsilon=0, 64 draws with Greedy_Action=2'b11. Expected: Explore=0 and Action_Out=2'b11 on every draw; LFSR still advances once per draw (matches the model).
- RST pulsed low during DRAW of the first draw. Expected: no Valid; after release, repeating scenario 1 reproduces Action_Out=2'b10, Explore=1, Draw_Count=1.
- Req[2] dropped during DRAW after being selected. Expected: Grant=0100 is still issued; ptr moves to 3.
